// File: rtl/spi_pkg.sv
// Shared types and widths for the single-byte SPI master.
package spi_pkg;

  localparam int DATA_W    = 8;
  localparam int BIT_CNT_W = $clog2(DATA_W + 1);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

endpackage

// File: rtl/spi_clk_div.sv
// sclk generator: toggles sclk every CLK_DIV clk cycles while enabled and
// flags the clk cycle on which each sclk edge is produced.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] div_cnt_q;
  logic             sclk_q;
  logic             term;

  // Strobes are combinational so the master acts on the same posedge that
  // moves sclk, keeping mosi/rx updates aligned with the pin edge.
  assign term     = en && (div_cnt_q == CNT_MAX);
  assign rise_stb = term && !sclk_q;
  assign fall_stb = term && sclk_q;
  assign sclk     = sclk_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      sclk_q    <= 1'b0;
    end else if (!en) begin
      div_cnt_q <= '0;
      sclk_q    <= 1'b0;
    end else if (term) begin
      div_cnt_q <= '0;
      sclk_q    <= ~sclk_q;
    end else begin
      div_cnt_q <= div_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_master.sv
// Single-byte SPI master, mode 0. Define SPI_LSB_FIRST_EN to shift LSB first
// on both mosi and miso; the default build shifts MSB first.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_n,
  output logic              state
);

  state_e                 state_q;
  logic [DATA_W-1:0]      tx_sr_q;
  logic [DATA_W-1:0]      rx_sr_q;
  logic [DATA_W-1:0]      rx_data_q;
  logic [BIT_CNT_W-1:0]   bit_cnt_q;
  logic                   mosi_q;
  logic                   cs_n_q;
  logic                   busy_q;
  logic                   done_q;

  logic                   rise_stb;
  logic                   fall_stb;
  logic                   first_bit_d;
  logic                   next_bit_d;
  logic [DATA_W-1:0]      tx_shift_d;
  logic [DATA_W-1:0]      rx_shift_d;

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (state_q == XFER),
    .sclk     (sclk),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

`ifdef SPI_LSB_FIRST_EN
  assign first_bit_d = tx_data[0];
  assign tx_shift_d  = {1'b0, tx_sr_q[DATA_W-1:1]};
  assign rx_shift_d  = {miso, rx_sr_q[DATA_W-1:1]};
  assign next_bit_d  = tx_shift_d[0];
`else
  assign first_bit_d = tx_data[DATA_W-1];
  assign tx_shift_d  = {tx_sr_q[DATA_W-2:0], 1'b0};
  assign rx_shift_d  = {rx_sr_q[DATA_W-2:0], miso};
  assign next_bit_d  = tx_shift_d[DATA_W-1];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      bit_cnt_q <= '0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= XFER;
            tx_sr_q   <= tx_data;
            rx_sr_q   <= '0;
            bit_cnt_q <= '0;
            mosi_q    <= first_bit_d;
            cs_n_q    <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        XFER: begin
          if (rise_stb) begin
            rx_sr_q   <= rx_shift_d;
            bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
          end
          // The falling edge after the last sampled bit closes the frame.
          if (fall_stb) begin
            if (bit_cnt_q < BIT_CNT_W'(DATA_W)) begin
              tx_sr_q <= tx_shift_d;
              mosi_q  <= next_bit_d;
            end else begin
              state_q   <= IDLE;
              cs_n_q    <= 1'b1;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              rx_data_q <= rx_sr_q;
              mosi_q    <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;
  assign state   = state_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master (CLK_DIV=4) with a mode-0 slave model on miso.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       busy;
  logic       done;
  logic       sclk;
  logic       mosi;
  logic       miso_w;
  logic       cs_n;
  logic       state;

  int checks = 0;
  int errors = 0;

  // slave / monitor state
  logic       loop_en    = 1'b0;
  logic [7:0] slave_byte = 8'h00;
  logic       slave_miso = 1'b0;
  logic       prev_sclk  = 1'b0;
  logic       prev_cs_n  = 1'b1;
  logic [7:0] mon_mosi   = 8'h00;
  int         fall_cnt   = 0;
  int         rise_total = 0;
  int         done_total = 0;
  int         busy_total = 0;

  int r0, d0, b0;
  int cyc;
  bit found;

  // clock / reset block
  always #5 clk = ~clk;

  spi_master #(
    .CLK_DIV (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .tx_data (tx_data),
    .rx_data (rx_data),
    .busy    (busy),
    .done    (done),
    .sclk    (sclk),
    .mosi    (mosi),
    .miso    (miso_w),
    .cs_n    (cs_n),
    .state   (state)
  );

  assign miso_w = loop_en ? mosi : slave_miso;

  // Mode-0 slave: presents its MSB when selected, next bit after each sclk fall.
  always @(negedge clk) begin
    int nf;
    if (cs_n === 1'b0 && prev_cs_n === 1'b1) begin
      fall_cnt   <= 0;
      slave_miso <= slave_byte[7];
    end
    if (sclk === 1'b1 && prev_sclk === 1'b0) begin
      rise_total <= rise_total + 1;
      mon_mosi   <= {mon_mosi[6:0], mosi};
    end
    if (sclk === 1'b0 && prev_sclk === 1'b1 && cs_n === 1'b0) begin
      nf = fall_cnt + 1;
      fall_cnt <= nf;
      if (nf < 8) slave_miso <= slave_byte[7-nf];
    end
    if (busy === 1'b1) busy_total <= busy_total + 1;
    if (done === 1'b1) done_total <= done_total + 1;
    prev_sclk <= sclk;
    prev_cs_n <= cs_n;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    #1;
    r0 = rise_total;
    d0 = done_total;
    b0 = busy_total;
  endtask

  // driver: one-cycle start pulse, then scramble tx_data to prove it is latched
  task automatic start_xfer(input logic [7:0] d);
    @(negedge clk);
    start   = 1'b1;
    tx_data = d;
    @(negedge clk);
    start   = 1'b0;
    tx_data = ~d;
  endtask

  task automatic wait_done(output int cycles, output bit seen);
    seen   = 1'b0;
    cycles = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cycles = i;
        seen   = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    tx_data = 8'h00;

    // reset
    repeat (5) @(negedge clk);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rx", 32'(rx_data), 32'h00);
    check("rst_state", 32'(state), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    rst_n = 1'b1;

    // basic transfer A5 out, 3C in
    slave_byte = 8'h3C;
    snap();
    start_xfer(8'hA5);
    check("basic_busy", 32'(busy), 32'd1);
    check("basic_cs_n", 32'(cs_n), 32'd0);
    check("basic_state", 32'(state), 32'd1);
    check("basic_mosi0", 32'(mosi), 32'd1);
    wait_done(cyc, found);
    check("basic_done_seen", 32'(found), 32'd1);
    check("basic_cycles", 32'(cyc), 32'd64);
    check("basic_rx", 32'(rx_data), 32'h3C);
    check("basic_busy_end", 32'(busy), 32'd0);
    check("basic_cs_n_end", 32'(cs_n), 32'd1);
    check("basic_sclk_end", 32'(sclk), 32'd0);
    check("basic_mosi_end", 32'(mosi), 32'd0);
    @(negedge clk);
    #1;
    check("basic_done_pulse", 32'(done), 32'd0);
    check("basic_rises", 32'(rise_total - r0), 32'd8);
    check("basic_dones", 32'(done_total - d0), 32'd1);
    check("basic_busy_cycles", 32'(busy_total - b0), 32'd64);
    check("basic_mosi_stream", 32'(mon_mosi), 32'hA5);

    // loopback
    loop_en = 1'b1;
    snap();
    start_xfer(8'h5A);
    wait_done(cyc, found);
    check("loop_done_seen", 32'(found), 32'd1);
    check("loop_rx", 32'(rx_data), 32'h5A);
    @(negedge clk);
    #1;
    check("loop_mosi_stream", 32'(mon_mosi), 32'h5A);
    loop_en = 1'b0;

    // start while busy is ignored
    slave_byte = 8'h96;
    snap();
    start_xfer(8'h81);
    repeat (20) @(negedge clk);
    start   = 1'b1;
    tx_data = 8'hFF;
    @(negedge clk);
    start   = 1'b0;
    check("busy_ign_busy", 32'(busy), 32'd1);
    wait_done(cyc, found);
    check("busy_ign_done_seen", 32'(found), 32'd1);
    check("busy_ign_cycles", 32'(cyc), 32'd43);
    check("busy_ign_rx", 32'(rx_data), 32'h96);
    repeat (3) @(negedge clk);
    #1;
    check("busy_ign_state", 32'(state), 32'd0);
    check("busy_ign_dones", 32'(done_total - d0), 32'd1);
    check("busy_ign_mosi_stream", 32'(mon_mosi), 32'h81);

    // back-to-back: start on the done cycle
    slave_byte = 8'hA6;
    start_xfer(8'hC3);
    wait_done(cyc, found);
    check("b2b_first_done_seen", 32'(found), 32'd1);
    check("b2b_first_rx", 32'(rx_data), 32'hA6);
    check("b2b_cs_n_gap", 32'(cs_n), 32'd1);
    slave_byte = 8'h5B;
    start   = 1'b1;
    tx_data = 8'h0F;
    @(negedge clk);
    start   = 1'b0;
    tx_data = 8'hF0;
    check("b2b_cs_n_low", 32'(cs_n), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_state", 32'(state), 32'd1);
    check("b2b_mosi0", 32'(mosi), 32'd0);
    wait_done(cyc, found);
    check("b2b_second_done_seen", 32'(found), 32'd1);
    check("b2b_second_cycles", 32'(cyc), 32'd64);
    check("b2b_second_rx", 32'(rx_data), 32'h5B);
    @(negedge clk);
    #1;
    check("b2b_mosi_stream", 32'(mon_mosi), 32'h0F);

    // reset mid-transfer after three sclk edges
    slave_byte = 8'h77;
    snap();
    start_xfer(8'hE7);
    repeat (13) @(negedge clk);
    check("abort_sclk_before", 32'(sclk), 32'd1);
    check("abort_mosi_before", 32'(mosi), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_sclk", 32'(sclk), 32'd0);
    check("abort_cs_n", 32'(cs_n), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_rx", 32'(rx_data), 32'h00);
    check("abort_state", 32'(state), 32'd0);
    check("abort_mosi", 32'(mosi), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("abort_no_done", 32'(done_total - d0), 32'd0);

    // normal transfer after the abort
    slave_byte = 8'hC9;
    start_xfer(8'h3C);
    wait_done(cyc, found);
    check("post_done_seen", 32'(found), 32'd1);
    check("post_cycles", 32'(cyc), 32'd64);
    check("post_rx", 32'(rx_data), 32'hC9);
    @(negedge clk);
    #1;
    check("post_mosi_stream", 32'(mon_mosi), 32'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
